alu_seq_n: RTL and testbench
============================

ALU_SEQ_N -- requirements
Module: alu_seq_n

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width; WIDTH >= 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), SHALL set the iteration-counter width.
REQ-003 clk  input  1  SHALL be the single clock; every flop SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request an operation; it is sampled only in IDLE.
REQ-006 op  input  3  SHALL select the operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 illegal.
REQ-007 in_a, in_b  input  WIDTH each  SHALL be signed operands.
REQ-008 result  output  2*WIDTH  SHALL be the registered signed result.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 zero, neg, ovf, dbz, ill  output  1 each  SHALL be registered flags, updated together with result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-013 Transitions SHALL be: IDLE->EXEC on start; EXEC->DONE when the op completes; DONE->IDLE unconditionally.
REQ-014 On the accepting edge k, in_a, in_b and op SHALL be captured; later input changes SHALL have no effect.
REQ-015 start while busy=1 (including in DONE) SHALL be ignored without being queued.
REQ-016 ADD, SUB, AND, OR, XOR and illegal ops SHALL load result and flags at edge k+1, with done high for the cycle after that edge.
REQ-017 MUL and non-zero-divisor DIV SHALL run WIDTH iterations at edges k+1..k+WIDTH, with result and flags loaded at edge k+WIDTH+1.
REQ-018 ADD/SUB SHALL produce the exact sign-extended 2*WIDTH sum/difference; ovf=1 when the WIDTH-bit signed result would overflow.
REQ-019 AND/OR/XOR SHALL place the bitwise result in the low WIDTH bits and zero-extend it; ovf=0.
REQ-020 MUL SHALL use shift-add on operand magnitudes with a final sign correction, giving the exact signed 2*WIDTH product; ovf=0.
REQ-021 DIV SHALL use restoring division on magnitudes: quotient truncated toward zero, remainder taking the dividend's sign; result = {remainder, quotient}.
REQ-022 DIV of the most-negative value by -1 SHALL return quotient = most-negative value, remainder 0, ovf=1.
REQ-023 DIV with divisor 0 SHALL skip iteration and complete at k+1 with quotient all-ones, remainder = in_a, dbz=1.
REQ-024 op 7 SHALL complete at k+1 with result 0 and ill=1.
REQ-025 zero SHALL equal (result==0), and neg SHALL equal result[2*WIDTH-1].
REQ-026 result and flags SHALL hold until the next completion; done SHALL last exactly one cycle per accepted start.

Reset
REQ-027 reset SHALL force IDLE and clear result, done, busy, all flags, the counter and all datapath registers on the next edge.
REQ-028 reset SHALL take priority over start and over an in-progress MUL/DIV, which SHALL be aborted with no done pulse.
REQ-029 With reset high on the same edge as start, the start SHALL be discarded.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the opcode constants, the state enum and the flag bit positions.
REQ-031 The iterative MUL/DIV datapath (accumulator, shifter, counter) SHALL be one sub-module, alu_seq_iter, parametrised by WIDTH.
REQ-032 The FSM, operand capture, single-cycle ops and output registers SHALL reside in alu_seq_n.

Verification (WIDTH=8)
REQ-033 ADD 100+100 -> result 16'h00C8, ovf=1, done one cycle after edge k+1.
REQ-034 MUL -128*-128 -> result 16'h4000, done exactly after edge k+9, busy high for 10 cycles.
REQ-035 DIV -7/2 -> result 16'hFFFD (rem -1, quot -3), neg=1; DIV -128/-1 -> low byte 8'h80, ovf=1.
REQ-036 DIV 5/0 -> result 16'h05FF, dbz=1, done after edge k+1.
REQ-037 start MUL, assert reset at edge k+4 -> no done pulse, result 0, busy 0, then a fresh ADD 1+2 -> 16'h0003.
REQ-038 start pulsed during EXEC and DONE, plus inputs changed mid-MUL -> exactly one done, result from the captured operands.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU.
//   - opcode constants for the 3-bit op input
//   - controller state enum
//   - bit positions of the packed flag vector {ill, dbz, ovf, neg, zero}
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_DBZ  = 3;
  localparam int FLAG_ILL  = 4;
  localparam int FLAG_W    = 5;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative unsigned multiply / restoring divide engine.
// Works on operand magnitudes; sign handling is done by the caller.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : start a new run with a_mag / b_mag / is_div
//   is_div          : 1 = divide (a_mag / b_mag), 0 = multiply (a_mag * b_mag)
//   a_mag, b_mag    : WIDTH-bit unsigned magnitudes
//   acc             : MUL -> 2*WIDTH product; DIV -> {remainder, quotient}
//   iter_done       : high once WIDTH iterations have completed
module alu_seq_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 iter_done
);

  // One shared 2*WIDTH register: for MUL the high half accumulates partial
  // sums while the multiplier shifts out of the low half; for DIV the high
  // half is the partial remainder and the quotient shifts into the low half.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               div_q, div_d;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] r_diff;

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    div_d   = div_q;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    r_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    r_diff  = r_shift - {1'b0, opnd_q};

    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, a_mag};
      opnd_d = b_mag;
      cnt_d  = '0;
      run_d  = 1'b1;
      div_d  = is_div;
    end else if (run_q) begin
      if (div_q) begin
        // Borrow out of the trial subtraction means restore (quotient bit 0).
        acc_d = r_diff[WIDTH] ? {r_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {r_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      div_q  <= div_d;
    end
  end

  assign acc       = acc_q;
  assign iter_done = !run_q && (cnt_q == CNT_W'(WIDTH));

endmodule

// File: rtl/alu_seq_n.sv
// Sequential signed ALU: single-cycle ADD/SUB/AND/OR/XOR, iterative MUL/DIV.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, op            : request (sampled in IDLE only) and opcode
//   in_a, in_b           : WIDTH-bit signed operands, captured on accept
//   result               : registered 2*WIDTH signed result
//   done                 : one-cycle completion pulse
//   busy                 : high while not IDLE
//   zero/neg/ovf/dbz/ill : registered flags, loaded together with result
module alu_seq_n
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic                 zero,
  output logic                 neg,
  output logic                 ovf,
  output logic                 dbz,
  output logic                 ill
);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [FLAG_W-1:0]    flags_q, flags_d;

  logic                 iter_load;
  logic [2*WIDTH-1:0]   iter_acc;
  logic                 iter_done;

  logic [2*WIDTH-1:0]   res_c;
  logic [FLAG_W-1:0]    flags_c;
  logic [2*WIDTH-1:0]   sum_c, diff_c;
  logic [WIDTH-1:0]     quot_c, rem_c;
  logic                 iter_op;

  // The engine is loaded on the accepting edge straight from the inputs so
  // that its WIDTH iterations occupy the following WIDTH edges.
  alu_seq_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (iter_load),
    .is_div    (op == OP_DIV),
    .a_mag     (mag(in_a)),
    .b_mag     (mag(in_b)),
    .acc       (iter_acc),
    .iter_done (iter_done)
  );

  assign iter_op = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));

  // Final result and flags from the captured operands.
  always_comb begin
    res_c   = '0;
    flags_c = '0;
    sum_c   = {{WIDTH{a_q[WIDTH-1]}}, a_q} + {{WIDTH{b_q[WIDTH-1]}}, b_q};
    diff_c  = {{WIDTH{a_q[WIDTH-1]}}, a_q} - {{WIDTH{b_q[WIDTH-1]}}, b_q};
    quot_c  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -iter_acc[WIDTH-1:0] : iter_acc[WIDTH-1:0];
    rem_c   = a_q[WIDTH-1] ? -iter_acc[2*WIDTH-1:WIDTH] : iter_acc[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_ADD: begin
        res_c = sum_c;
        flags_c[FLAG_OVF] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff_c;
        flags_c[FLAG_OVF] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_c = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -iter_acc : iter_acc;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_c = {a_q, {WIDTH{1'b1}}};
          flags_c[FLAG_DBZ] = 1'b1;
        end else begin
          res_c = {rem_c, quot_c};
          // MIN / -1: the magnitude quotient already wraps to MIN.
          flags_c[FLAG_OVF] = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        end
      end
      OP_AND: res_c = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  res_c = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: res_c = {{WIDTH{1'b0}}, a_q ^ b_q};
      default: flags_c[FLAG_ILL] = 1'b1;
    endcase
    flags_c[FLAG_ZERO] = (res_c == '0);
    flags_c[FLAG_NEG]  = res_c[2*WIDTH-1];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    iter_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_EXEC;
          op_d      = op;
          a_d       = in_a;
          b_d       = in_b;
          iter_load = (op == OP_MUL) || ((op == OP_DIV) && (in_b != '0));
        end
      end
      ST_EXEC: begin
        if (!iter_op || iter_done) begin
          state_d  = ST_DONE;
          result_d = res_c;
          flags_d  = flags_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE);
  assign zero   = flags_q[FLAG_ZERO];
  assign neg    = flags_q[FLAG_NEG];
  assign ovf    = flags_q[FLAG_OVF];
  assign dbz    = flags_q[FLAG_DBZ];
  assign ill    = flags_q[FLAG_ILL];

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n (WIDTH=8): directed corner cases plus
// randomized operations compared against an integer-arithmetic model.
module tb_alu_seq_n;

  localparam int W    = 8;
  localparam int MAXV = (2 ** (W - 1)) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [W-1:0]     in_a, in_b;
  logic [2*W-1:0]   result;
  logic             done, busy, zero, neg, ovf, dbz, ill;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_seq_n #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .in_a   (in_a),
    .in_b   (in_b),
    .result (result),
    .done   (done),
    .busy   (busy),
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf),
    .dbz    (dbz),
    .ill    (ill)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: plain signed integer arithmetic. Flags packed {zero,neg,ovf,dbz,ill}.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [2*W-1:0] r, output logic [4:0] f);
    int sa, sb, s, q, m;
    logic v_ovf, v_dbz, v_ill;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v_ovf = 0; v_dbz = 0; v_ill = 0;
    r = '0;
    case (o)
      3'd0: begin s = sa + sb; r = (2*W)'(s); v_ovf = (s > MAXV) || (s < MINV); end
      3'd1: begin s = sa - sb; r = (2*W)'(s); v_ovf = (s > MAXV) || (s < MINV); end
      3'd2: begin s = sa * sb; r = (2*W)'(s); end
      3'd3: begin
        if (sb == 0) begin
          r = {a, {W{1'b1}}}; v_dbz = 1;
        end else if (sa == MINV && sb == -1) begin
          r = {{W{1'b0}}, a}; v_ovf = 1;
        end else begin
          q = sa / sb; m = sa % sb;
          r = {m[W-1:0], q[W-1:0]};
        end
      end
      3'd4: r = {{W{1'b0}}, a & b};
      3'd5: r = {{W{1'b0}}, a | b};
      3'd6: r = {{W{1'b0}}, a ^ b};
      default: v_ill = 1;
    endcase
    f = {r == '0, r[2*W-1], v_ovf, v_dbz, v_ill};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise, input string tag);
    logic [2*W-1:0] exp_r;
    logic [4:0]     exp_f;
    int exp_lat, e, busy_n;
    bit found;
    ref_op(o, a, b, exp_r, exp_f);
    exp_lat = (o == 3'd2 || (o == 3'd3 && b != '0)) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(negedge clk);  // accepting edge k has passed
    start = 1'b0;
    e = 0; busy_n = 0; found = 0;
    while (e < 40) begin
      if (busy) busy_n++;
      if (done) begin found = 1; break; end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom);
        in_a  = W'($urandom);
        in_b  = W'($urandom);
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(found), 64'd1);
    check({tag, " latency"}, 64'(e), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat + 1));
    check({tag, " result"}, 64'(result), 64'(exp_r));
    check({tag, " flags"}, 64'({zero, neg, ovf, dbz, ill}), 64'(exp_f));
    $display("op=%0d a=%0h b=%0h result=%0h flags=%b lat=%0d", o, a, b, result,
             {zero, neg, ovf, dbz, ill}, e);
    @(negedge clk);
    check({tag, " done_1cyc"}, 64'(done), 64'd0);
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   ro;
    int dn;
    reset = 1'b1; start = 1'b0; op = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("rst result", 64'(result), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst flags", 64'({zero, neg, ovf, dbz, ill}), 64'd0);
    reset = 1'b0;

    run_op(3'd0, 8'd100, 8'd100, 0, "add_ovf");
    run_op(3'd2, 8'h80, 8'h80, 0, "mul_min");
    run_op(3'd3, 8'hF9, 8'h02, 0, "div_m7_2");
    run_op(3'd3, 8'h80, 8'hFF, 0, "div_min_m1");
    run_op(3'd3, 8'h05, 8'h00, 0, "div_zero");
    run_op(3'd7, 8'h12, 8'h34, 0, "illegal");
    run_op(3'd1, 8'h80, 8'h01, 0, "sub_ovf");
    run_op(3'd4, 8'hF0, 8'h3C, 0, "and");
    run_op(3'd5, 8'hF0, 8'h0C, 0, "or");
    run_op(3'd6, 8'hFF, 8'h0F, 0, "xor");
    run_op(3'd2, 8'h85, 8'h13, 1, "mul_noise");

    // Reset in the middle of a MUL aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 3'd2; in_a = 8'h07; in_b = 8'h09;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort result", 64'(result), 64'd0);
    check("abort done", 64'(done), 64'd0);
    dn = 0;
    repeat (15) begin @(negedge clk); if (done || busy) dn++; end
    check("abort no_done", 64'(dn), 64'd0);
    run_op(3'd0, 8'd1, 8'd2, 0, "add_after_abort");

    // Start coinciding with reset is discarded.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 3'd0; in_a = 8'd3; in_b = 8'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_start busy2", 64'(busy), 64'd0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 8'h80;
        1: ra = 8'hFF;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = 8'h00;
        1: rb = 8'hFF;
        2: rb = 8'h80;
        default: rb = W'($urandom);
      endcase
      ro = 3'($urandom_range(0, 7));
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
